// File: rtl/mm_pkg.sv
// Shared types and helpers for the systolic matrix-multiply engine.
package mm_pkg;
  typedef enum logic [1:0] {IDLE, FEED, DONE} state_e;

  function automatic int acc_width(input int w, input int n);
    return 2 * w + $clog2(n);
  endfunction

  // Element (r,c) lives at slot elem_idx in a flat bus; row 0 col 0 sits in the MSBs.
  function automatic int elem_idx(input int r, input int c, input int n);
    return n * n - 1 - (r * n + c);
  endfunction
endpackage

// File: rtl/mm_pe.sv
// One output-stationary MAC cell: accumulates a*b, forwards a right and b down.
module mm_pe #(
  parameter int W      = 16,
  parameter int ACC_W  = 34,
  parameter int SIGNED = 0
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             clr,
  input  logic             en,
  input  logic [W-1:0]     a_in,
  input  logic [W-1:0]     b_in,
  output logic [W-1:0]     a_out,
  output logic [W-1:0]     b_out,
  output logic [ACC_W-1:0] acc
);
  localparam bit SX = (SIGNED != 0);

  logic [W-1:0]     a_q, b_q;
  logic [ACC_W-1:0] acc_q;
  logic [2*W-1:0]   ax, bx, prod;
  logic [ACC_W-1:0] pext;

  // Low 2W bits of the extended product are exact for both signednesses.
  always_comb begin
    ax   = {{W{SX & a_in[W-1]}}, a_in};
    bx   = {{W{SX & b_in[W-1]}}, b_in};
    prod = ax * bx;
    pext = {{(ACC_W-2*W){SX & prod[2*W-1]}}, prod};
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      a_q   <= '0;
      b_q   <= '0;
      acc_q <= '0;
    end else begin
      if (clr)     acc_q <= '0;
      else if (en) acc_q <= acc_q + pext;
      if (en) begin
        a_q <= a_in;
        b_q <= b_in;
      end
    end
  end

  assign a_out = a_q;
  assign b_out = b_q;
  assign acc   = acc_q;
endmodule

// File: rtl/systolic_mm_engine.sv
// N x N output-stationary systolic matmul: latch operands, feed skewed, hold C until taken.
module systolic_mm_engine import mm_pkg::*; #(
  parameter int W      = 16,
  parameter int N      = 3,
  parameter int SIGNED = 0,
  parameter int ACC_W  = acc_width(W, N)
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_valid,
  output logic                 o_ready,
  input  logic [W*N*N-1:0]     i_A,
  input  logic [W*N*N-1:0]     i_B,
  input  logic                 i_acc,
  output logic                 o_valid,
  input  logic                 i_ready,
  output logic [ACC_W*N*N-1:0] o_C,
  output logic                 o_busy
);
  localparam int TW = $clog2(3*N-1);
  localparam logic [TW-1:0] T_LAST = TW'(3*N-3);

  state_e           state_q, state_d;
  logic [TW-1:0]    t_q, t_d;
  logic [W*N*N-1:0] a_lat_q, b_lat_q;
  logic             accept, en, clr;

  assign o_ready = (state_q == IDLE);
  assign o_valid = (state_q == DONE);
  assign o_busy  = (state_q != IDLE);
  assign accept  = i_valid & o_ready;
  assign en      = (state_q == FEED);
  assign clr     = accept & ~i_acc;

  always_comb begin
    state_d = state_q;
    t_d     = t_q;
    case (state_q)
      IDLE: if (accept) begin
        state_d = FEED;
        t_d     = '0;
      end
      FEED: if (t_q == T_LAST) state_d = DONE;
            else               t_d     = t_q + TW'(1);
      DONE: if (i_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      t_q     <= '0;
      a_lat_q <= '0;
      b_lat_q <= '0;
    end else begin
      state_q <= state_d;
      t_q     <= t_d;
      if (accept) begin
        a_lat_q <= i_A;
        b_lat_q <= i_B;
      end
    end
  end

  // Row i carries A[i][t-i], column j carries B[t-j][j]; zero outside the band.
  logic [N-1:0][W-1:0] a_inj, b_inj;
  always_comb begin
    a_inj = '0;
    b_inj = '0;
    for (int i = 0; i < N; i++)
      for (int k = 0; k < N; k++)
        if (int'(t_q) == i + k) begin
          a_inj[i] = a_lat_q[elem_idx(i, k, N)*W +: W];
          b_inj[i] = b_lat_q[elem_idx(k, i, N)*W +: W];
        end
  end

  logic [N-1:0][N:0][W-1:0]         a_h;
  logic [N:0][N-1:0][W-1:0]         b_v;
  logic [N-1:0][N-1:0][ACC_W-1:0]   acc;

  for (genvar gi = 0; gi < N; gi++) begin : g_edge
    assign a_h[gi][0] = a_inj[gi];
    assign b_v[0][gi] = b_inj[gi];
  end

  for (genvar gr = 0; gr < N; gr++) begin : g_row
    for (genvar gc = 0; gc < N; gc++) begin : g_col
      mm_pe #(.W(W), .ACC_W(ACC_W), .SIGNED(SIGNED)) u_pe (
        .i_clk  (i_clk),
        .i_rst_n(i_rst_n),
        .clr    (clr),
        .en     (en),
        .a_in   (a_h[gr][gc]),
        .b_in   (b_v[gr][gc]),
        .a_out  (a_h[gr][gc+1]),
        .b_out  (b_v[gr+1][gc]),
        .acc    (acc[gr][gc])
      );
      assign o_C[elem_idx(gr, gc, N)*ACC_W +: ACC_W] = acc[gr][gc];
    end
  end

  // Operands leaving the far edge of the array have no consumer.
  logic unused_edge;
  always_comb begin
    unused_edge = 1'b0;
    for (int i = 0; i < N; i++)
      unused_edge = unused_edge ^ (^a_h[i][N]) ^ (^b_v[N][i]);
  end
endmodule

// File: doc/systolic_mm_engine.md
# systolic_mm_engine

Parametrised N×N output-stationary systolic matrix-multiply engine with a valid/ready handshake on both sides and an optional accumulate mode. It is the next generation of the fixed-size `control` unit. It latches one A/B operand pair, feeds the PE array with skewed rows and columns, then holds the full-width C result until the consumer takes it. It sits between the operand staging buffers and the result writeback path.

## Interface
- `W`, default 16: element width of A and B.
- `N`, default 3: matrix dimension; legal range 2..16.
- `SIGNED`, default 0: 0 = unsigned arithmetic, 1 = two's-complement arithmetic.
- `ACC_W`, default 2*W+$clog2(N): C element width; derived, not overridden.
- `i_clk`  in  1: single clock; everything is on the rising edge.
- `i_rst_n`  in  1: reset, synchronous and active-low.
- `i_valid`  in  1: operand pair on `i_A`/`i_B`/`i_acc` is valid.
- `o_ready`  out  1: engine accepts an operand pair this cycle.
- `i_A`  in  W*N*N: matrix A; element (r,c) at bits [(N*N-1-(r*N+c))*W +: W], so row 0 col 0 is in the MSBs.
- `i_B`  in  W*N*N: matrix B; same packing as `i_A`.
- `i_acc`  in  1: 1 = add A·B to the previous C; 0 = C = A·B.
- `o_valid`  out  1: `o_C` holds a completed result.
- `i_ready`  in  1: consumer takes `o_C` this cycle.
- `o_C`  out  ACC_W*N*N: result; same packing with element width ACC_W.
- `o_busy`  out  1: high in FEED or DONE.

## Operation
- States: IDLE, FEED, DONE.
- IDLE: `o_ready`=1. On `i_valid`&`o_ready`, latch A, B and `i_acc`, clear the feed counter t, and go to FEED. If the latched acc bit is 0, all PE accumulators clear on the same edge.
- FEED: t counts 0..3N-3. At cycle t, row i injects A[i][t-i] when 0≤t-i<N, otherwise 0. Column j injects B[t-j][j] under the same rule. Each PE computes acc += a·b and forwards a to the right and b downward with one register stage each. When t=3N-3, go to DONE.
- DONE: `o_valid`=1. On `i_ready`, go to IDLE. Accumulators are retained so the next operation can use `i_acc`=1.
- `o_ready` is high only in IDLE. There is no accept in the same cycle as the output handshake.
- Arithmetic: products are W×W→2W with SIGNED selecting sign extension. Accumulation is ACC_W wide and wraps modulo 2^ACC_W with no saturation. With `i_acc`=0 no wrap can occur.
- `i_acc`=1 as the first operation after reset gives the same result as `i_acc`=0, because accumulators reset to 0.
- `o_C` shows the accumulators directly and is meaningful only while `o_valid`=1.

## Timing
- Reset (`i_rst_n`=0 at an edge): state goes to IDLE. Outputs after reset: `o_ready`=1, `o_valid`=0, `o_busy`=0, `o_C`=0. All pipeline registers and accumulators are 0.
- Latency: accept edge = cycle 0. FEED occupies cycles 1..3N-2. `o_valid` rises at cycle 3N-1 (8 for N=3).
- Throughput: one operation per 3N cycles with no backpressure.
- Backpressure: while `i_ready`=0 in DONE, `o_valid` and `o_C` hold stable for any number of cycles.
- Reset mid-FEED or mid-DONE: the operation is discarded with no `o_valid` pulse. The engine comes back in IDLE with zeroed accumulators.
- `i_valid` outside IDLE is ignored; the upstream side must hold its data until `o_ready`.

## Structure
- Package `mm_pkg`:
  - state enum {IDLE, FEED, DONE};
  - function `acc_width(W,N)`;
  - function `elem_idx(r,c,N)` for the flat-bus slicing.
- Sub-module `mm_pe`: one MAC PE. Ports are a_in/b_in, a_out/b_out, clr, en, acc. Instantiate N×N in a generate loop.
- Top level holds the FSM, the feed counter, the operand latches and the skew multiplexers.

## Test plan
- W=16, N=3, all A and B elements = 0x0f0f, `i_acc`=0 → every C element = 0x2A848A3 (34-bit); `o_valid` at cycle 8 after accept.
- A = identity, B elements 1..9 row-major → C = B zero-extended to 34 bits.
- All elements 0xFFFF, unsigned → each C element = 0x2FFFA0003. With SIGNED=1, the same bits (−1) → each C element = 3.
- Accumulate: the 0x0f0f operation, then a second operation with `i_acc`=1 and the same operands → C = 0x5509146. A third operation with `i_acc`=0 → back to 0x2A848A3.
- Backpressure: hold `i_ready`=0 for 5 cycles in DONE → `o_valid` stays 1, `o_C` stays stable, `o_ready` stays 0. Assert `i_valid` during this window → no accept occurs.
- Reset: assert `i_rst_n`=0 at FEED t=3 → next cycle IDLE, `o_C`=0, no `o_valid`. A following normal operation produces the correct result.
